spi_fsm_slave: RTL and testbench
================================

# spi_fsm_slave

SPI responder for the far end of the link driven by our SPI master FSM. It runs on the master's gated SCLK and uses the active-low CS framing. Each frame it shifts F_SIZE bits in on MOSI and F_SIZE bits out on MISO, MSB first, in mode 0. It counts frames within an F_NUM-frame burst and presents each received word with a toggle strobe, so a downstream clock-domain crosser can pick it up.

## Interface
- F_NUM, 1: frames per burst.
- F_SIZE, 8: bits per frame.
- C_SIZE, $clog2(F_SIZE)+1: bit counter width.
- FC_SIZE, $clog2(F_NUM)+1: frame counter width.
- SCLK  in  1  serial clock from master; the only clock. Idle low, pulses only while a frame is active.
- rst  in  1  reset rst, asynchronous, active-high.
- CS  in  1  chip select, active low. High level asynchronously clears per-frame state.
- MOSI  in  1  serial data from master.
- MISO  out  1  serial data to master.
- tx_data_i  in  F_SIZE  word to send in the next frame. Must be stable from CS falling until the first SCLK falling edge.
- rx_data_o  out  F_SIZE  last complete word received.
- rx_frame_o  out  FC_SIZE  burst index (0..F_NUM-1) of rx_data_o.
- rx_last_o  out  1  high when rx_frame_o == F_NUM-1.
- rx_toggle_o  out  1  inverts once per completed frame.
- ovf_o  out  1  sticky: SCLK rising edge seen after a frame completed in the same CS-low window.

## Operation
- FSM states and transitions:
  - IDLE: entered on rst or CS high. First SCLK rising edge with CS low → SHIFT.
  - SHIFT: bits being captured. Rising edge that captures bit F_SIZE-1 → FULL.
  - FULL: extra SCLK rising edges set ovf_o; data is ignored. CS high → IDLE.
- bit_cnt (C_SIZE bits): 0 in IDLE. Increments on each SCLK rising edge in SHIFT. Cleared asynchronously while CS or rst is high.
- Receive path:
  - rx_sr shifts left, taking MOSI in at bit 0 on every SHIFT rising edge.
  - On the F_SIZE-th rising edge, all of the following happen together:
    - rx_data_o ← {rx_sr[F_SIZE-2:0], MOSI}
    - rx_frame_o ← f_cnt
    - rx_toggle_o inverts
    - f_cnt ← (f_cnt == F_NUM-1) ? 0 : f_cnt+1
- f_cnt (FC_SIZE bits) is reset only by rst. CS high does not clear it; the burst position survives inter-frame CS gaps.
- Aborted frame: CS rises with bit_cnt in 1..F_SIZE-1.
  - Partial data is discarded.
  - rx_data_o, rx_frame_o, rx_toggle_o and f_cnt are unchanged.
  - No error flag is raised.
- Transmit path:
  - MISO = tx_data_i[F_SIZE-1] while bit_cnt == 0.
  - Otherwise MISO = tx_sr[F_SIZE-1].
  - tx_sr loads {tx_data_i[F_SIZE-2:0], 1'b0} on the falling edge after bit 0, then shifts left on each later SCLK falling edge.
  - MISO = 0 while CS is high.
- ovf_o clears only on rst.

## Timing
- Mode 0 (CPOL=0, CPHA=0): MOSI sampled on SCLK rising edge; MISO changes on SCLK falling edge.
- Reset values: MISO 0, rx_data_o 0, rx_frame_o 0, rx_last_o 0, rx_toggle_o 0, ovf_o 0, f_cnt 0, state IDLE.
- Receive latency: rx_data_o is valid immediately after the F_SIZE-th SCLK rising edge, which is 0 SCLK cycles after the last bit.
- The outputs then hold until the next completed frame. SCLK stops between frames, so consumers must sample rx_toggle_o through a synchronizer and read rx_data_o after observing the toggle.
- Transmit: MISO bit k is valid from falling edge k-1 (bit 0 from CS falling) until falling edge k.
- Simultaneous events:
  - rst dominates everything.
  - CS rising and an SCLK edge together: CS wins, state → IDLE.
  - F_SIZE-th edge and f_cnt wrap on the same edge: the completed frame reports the pre-wrap index.
- Mid-frame rst: all outputs return to reset values immediately, and the frame is lost.

## Configuration
- SPI_SLAVE_MISO_EN defined: the transmit path (tx_sr, negedge logic, MISO mux) is present.
- SPI_SLAVE_MISO_EN undefined:
  - Receive-only build.
  - MISO is tied to 0.
  - tx_data_i is ignored.
  - No falling-edge flops are synthesized.
  - Receive behaviour is identical in both builds.

## Structure
- spi_pkg: shared state_t for the slave (IDLE, SHIFT, FULL) and the SPI mode constants CPOL=0, CPHA=0.
- Width parameters stay module parameters.
- One sub-module: spi_shift_reg, a parameterized F_SIZE shift register with load, used for rx_sr and tx_sr. The edge is selected by the instantiating always block.

## Test plan
Defaults for all scenarios: F_SIZE=8, F_NUM=2.
- Reset: assert rst with CS=0 and SCLK toggling → all outputs 0; MISO 0; no rx_toggle_o change.
- Single frame:
  - Stimulus: CS low, tx_data_i=8'hC3, MOSI shifts 8'hA5, 8 SCLK pulses.
  - Required: rx_data_o=8'hA5, rx_frame_o=0, rx_toggle_o=1, rx_last_o=0, and MISO sequence 1,1,0,0,0,0,1,1.
- Burst wrap:
  - Stimulus: two frames (8'h01, 8'h02) with CS high between them, then a third frame 8'h03.
  - Required: rx_frame_o goes 0, 1, 0; rx_last_o is high only for 8'h02; rx_toggle_o ends at 1.
- Abort:
  - Stimulus: 5 SCLK pulses, then CS high, then a full frame 8'h7E.
  - Required: rx_data_o holds its prior value through the abort; then rx_data_o=8'h7E with rx_frame_o equal to the pre-abort index.
- Overflow: 9 SCLK pulses in one CS-low window → rx_data_o from the first 8 bits; ovf_o=1 until rst.
- Build without SPI_SLAVE_MISO_EN: repeat the single-frame scenario → MISO constant 0; receive results identical.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type and SPI mode constants for the SPI link.
package spi_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;
   localparam bit CPOL = 1'b0;
   localparam bit CPHA = 1'b0;
endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: next-value logic of a loadable MSB-first shift register; the caller owns the flop and its edge.
module spi_shift_reg #(
   parameter int F_SIZE = 8
) (
   input  logic [F_SIZE-1:0] q,
   input  logic              load,
   input  logic [F_SIZE-1:0] load_val,
   input  logic              sin,
   output logic [F_SIZE-1:0] d
);
   assign d = load ? load_val : (q << 1) | F_SIZE'(sin);
endmodule

// File: rtl/spi_fsm_slave.sv
// spi_fsm_slave: mode-0 SPI responder with burst frame counter and toggle-strobed receive word.
// Define SPI_SLAVE_MISO_EN to build the transmit path; otherwise receive-only with MISO tied low.
module spi_fsm_slave
   import spi_pkg::*;
#(
   parameter int F_NUM   = 1,
   parameter int F_SIZE  = 8,
   parameter int C_SIZE  = $clog2(F_SIZE) + 1,
   parameter int FC_SIZE = $clog2(F_NUM) + 1
) (
   input  logic               SCLK,
   input  logic               rst,
   input  logic               CS,
   input  logic               MOSI,
   output logic               MISO,
   input  logic [F_SIZE-1:0]  tx_data_i,
   output logic [F_SIZE-1:0]  rx_data_o,
   output logic [FC_SIZE-1:0] rx_frame_o,
   output logic               rx_last_o,
   output logic               rx_toggle_o,
   output logic               ovf_o
);
   state_t             state, state_nx;
   logic [C_SIZE-1:0]  bit_cnt;
   logic [FC_SIZE-1:0] f_cnt;
   logic [F_SIZE-1:0]  rx_sr, rx_nx;
   logic               shift, done;

   always_comb begin
      shift    = !CS && state != FULL;
      done     = shift && bit_cnt == C_SIZE'(F_SIZE - 1);
      state_nx = done ? FULL : shift ? SHIFT : state;
   end

   spi_shift_reg #(.F_SIZE(F_SIZE)) u_rx (
      .q(rx_sr), .load(1'b0), .load_val('0), .sin(MOSI), .d(rx_nx)
   );

   // Per-frame state: CS high discards any partial frame
   always_ff @(posedge SCLK or posedge rst or posedge CS)
      if (rst || CS) begin
         state   <= IDLE;
         bit_cnt <= '0;
         rx_sr   <= '0;
      end else begin
         state <= state_nx;
         if (shift) begin
            bit_cnt <= bit_cnt + 1'b1;
            rx_sr   <= rx_nx;
         end
      end

   // Burst position and results survive CS gaps; only rst clears them
   always_ff @(posedge SCLK or posedge rst)
      if (rst) begin
         rx_data_o   <= '0;
         rx_frame_o  <= '0;
         rx_last_o   <= 1'b0;
         rx_toggle_o <= 1'b0;
         ovf_o       <= 1'b0;
         f_cnt       <= '0;
      end else begin
         if (!CS && state == FULL) ovf_o <= 1'b1;
         if (done) begin
            rx_data_o   <= rx_nx;
            rx_frame_o  <= f_cnt;
            rx_last_o   <= f_cnt == FC_SIZE'(F_NUM - 1);
            rx_toggle_o <= ~rx_toggle_o;
            f_cnt       <= f_cnt == FC_SIZE'(F_NUM - 1) ? '0 : f_cnt + 1'b1;
         end
      end

`ifdef SPI_SLAVE_MISO_EN
   logic [F_SIZE-1:0] tx_sr, tx_nx;

   spi_shift_reg #(.F_SIZE(F_SIZE)) u_tx (
      .q(tx_sr), .load(bit_cnt == C_SIZE'(1)), .load_val({tx_data_i[F_SIZE-2:0], 1'b0}),
      .sin(1'b0), .d(tx_nx)
   );

   always_ff @(negedge SCLK or posedge rst or posedge CS)
      if (rst || CS) tx_sr <= '0;
      else tx_sr <= tx_nx;

   assign MISO = (rst || CS) ? 1'b0 : bit_cnt == '0 ? tx_data_i[F_SIZE-1] : tx_sr[F_SIZE-1];
`else
   logic unused_tx;
   assign unused_tx = ^tx_data_i;
   assign MISO      = 1'b0;
`endif
endmodule

// File: tb/tb_spi_fsm_slave.sv
// tb_spi_fsm_slave: directed and randomized frames checked against a frame-level model of the responder.
module tb_spi_fsm_slave;
   localparam int F_NUM = 2, F_SIZE = 8, FC_SIZE = $clog2(F_NUM) + 1;

   logic SCLK = 0, rst = 1, CS = 0, MOSI = 0, MISO;
   logic [F_SIZE-1:0] tx_data_i = '1, rx_data_o;
   logic [FC_SIZE-1:0] rx_frame_o;
   logic rx_last_o, rx_toggle_o, ovf_o;

   int checks = 0, errors = 0;
   logic [7:0] m_data = 0;
   int m_frame = 0, m_fcnt = 0;
   logic m_toggle = 0, m_ovf = 0;

   spi_fsm_slave #(.F_NUM(F_NUM), .F_SIZE(F_SIZE)) dut (
      .SCLK(SCLK), .rst(rst), .CS(CS), .MOSI(MOSI), .MISO(MISO), .tx_data_i(tx_data_i),
      .rx_data_o(rx_data_o), .rx_frame_o(rx_frame_o), .rx_last_o(rx_last_o),
      .rx_toggle_o(rx_toggle_o), .ovf_o(ovf_o)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".data"}, 16'(rx_data_o), 16'(m_data));
      check({tag, ".frame"}, 16'(rx_frame_o), 16'(m_frame));
      check({tag, ".last"}, 16'(rx_last_o), 16'(m_frame == F_NUM - 1));
      check({tag, ".toggle"}, 16'(rx_toggle_o), 16'(m_toggle));
      check({tag, ".ovf"}, 16'(ovf_o), 16'(m_ovf));
   endtask

   task automatic do_reset();
      rst = 1;
      #3;
      rst = 0;
      #3;
      m_data = 0; m_frame = 0; m_fcnt = 0; m_toggle = 0; m_ovf = 0;
   endtask

   // One CS-low window with n SCLK pulses; bits past the eighth are random
   task automatic frame(input string tag, input logic [7:0] tx, input logic [7:0] mosi, input int n);
      logic exp_miso;
      tx_data_i = tx;
      CS = 0;
      #5;
      for (int k = 0; k < n; k++) begin
         MOSI = k < 8 ? mosi[7-k] : 1'($urandom);
         #5;
`ifdef SPI_SLAVE_MISO_EN
         exp_miso = k < 8 ? tx[7-k] : 1'b0;
`else
         exp_miso = 1'b0;
`endif
         check({tag, ".miso"}, 16'(MISO), 16'(exp_miso));
         SCLK = 1;
         #5;
         SCLK = 0;
         #5;
      end
      CS = 1;
      #5;
      check({tag, ".miso_idle"}, 16'(MISO), 16'h0);
      if (n >= 8) begin
         m_data   = mosi;
         m_frame  = m_fcnt;
         m_fcnt   = (m_fcnt + 1) % F_NUM;
         m_toggle = ~m_toggle;
      end
      if (n > 8) m_ovf = 1;
      check_outputs(tag);
   endtask

   initial begin
      repeat (3) begin
         MOSI = 1'($urandom);
         #2 SCLK = 1;
         #2 SCLK = 0;
      end
      #1;
      check("rst.miso", 16'(MISO), 16'h0);
      check_outputs("rst");
      CS = 1;
      rst = 0;
      #5;
      check_outputs("post_rst");

      frame("single", 8'hC3, 8'hA5, 8);

      do_reset();
      frame("burst0", 8'h00, 8'h01, 8);
      frame("burst1", 8'h00, 8'h02, 8);
      frame("burst2", 8'h00, 8'h03, 8);

      frame("abort", 8'h5A, 8'hFF, 5);
      frame("after_abort", 8'h96, 8'h7E, 8);

      frame("ovf", 8'h81, 8'h3C, 9);
      frame("ovf_hold", 8'h42, 8'hE7, 8);

      for (int i = 0; i < 25; i++)
         frame("rand", 8'($urandom), 8'($urandom), int'($urandom_range(3, 10)));

      CS = 0;
      #5;
      repeat (4) begin
         MOSI = 1'($urandom);
         #5 SCLK = 1;
         #5 SCLK = 0;
      end
      #5 rst = 1;
      #1;
      m_data = 0; m_frame = 0; m_fcnt = 0; m_toggle = 0; m_ovf = 0;
      check("midrst.miso", 16'(MISO), 16'h0);
      check_outputs("midrst");
      rst = 0;
      CS = 1;
      #5;
      frame("after_midrst", 8'h3C, 8'hC9, 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
